// File: rtl/neuron_mac_ctrl.sv
// rtl/neuron_mac_ctrl.sv - single-neuron multiply-accumulate sequencer
//
// Walks N input/weight pairs from external memories, multiplies each pair as
// 8-bit sign-magnitude values into a 16-bit sign-magnitude product, and sums
// the products into an M-bit sign-magnitude accumulator with magnitude
// saturation. The activated accumulator is registered on result with done.
//
// Optional feature macro: NEURON_RELU_EN (defined -> negative results clamp to +0).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begin an evaluation (ignored while busy)
//   busy         evaluation in progress (FETCH/ACC/DONE)
//   rd_en        memory read strobe for idx
//   idx          pair index presented to both memories
//   x_in, w_in   sign-magnitude operands, valid the cycle after rd_en
//   result       sign-magnitude result, bit M-1 = sign
//   result_valid result holds a completed evaluation
//   done         one-cycle completion pulse

module neuron_mac_ctrl #(
    parameter int N = 4,
    parameter int M = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 rd_en,
    output logic [$clog2(N)-1:0] idx,
    input  logic [7:0]           x_in,
    input  logic [7:0]           w_in,
    output logic [M-1:0]         result,
    output logic                 result_valid,
    output logic                 done
);

    localparam int IW = $clog2(N);
    localparam int MW = M - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ACC,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [M-1:0]    acc_q;
    logic [IW-1:0]   idx_q;
    logic [M-1:0]    result_q;
    logic            rv_q;

    logic [14:0]     p_mag;
    logic            p_sign;
    logic [MW-1:0]   p_ext;
    logic [MW-1:0]   acc_mag;
    logic            acc_sign;
    logic [M-1:0]    sum;
    logic [M-1:0]    acc_next;
    logic [M-1:0]    act_next;
    logic            last_pair;

    // Product magnitude never exceeds 127*127 = 16129, so 15 bits are exact.
    assign p_mag    = 15'(x_in[6:0]) * 15'(w_in[6:0]);
    // A zero product is always +0 so the accumulator never sees -0.
    assign p_sign   = (x_in[7] ^ w_in[7]) & (p_mag != 15'd0);
    assign p_ext    = MW'(p_mag);
    assign acc_mag  = acc_q[MW-1:0];
    assign acc_sign = acc_q[M-1];
    assign sum      = {1'b0, acc_mag} + {1'b0, p_ext};
    assign last_pair = (idx_q == IW'(N - 1));

    always_comb begin
        acc_next = '0;
        if (acc_sign == p_sign) begin
            // Same sign: magnitudes add; a carry out of the magnitude field saturates.
            acc_next[M-1]    = acc_sign;
            acc_next[MW-1:0] = sum[MW] ? {MW{1'b1}} : sum[MW-1:0];
        end else if (acc_mag > p_ext) begin
            acc_next[M-1]    = acc_sign;
            acc_next[MW-1:0] = acc_mag - p_ext;
        end else if (p_ext > acc_mag) begin
            acc_next[M-1]    = p_sign;
            acc_next[MW-1:0] = p_ext - acc_mag;
        end
        // Equal magnitudes with opposite signs fall through to +0.
    end

    always_comb begin
`ifdef NEURON_RELU_EN
        act_next = acc_next[M-1] ? '0 : acc_next;
`else
        act_next = acc_next;
`endif
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        rd_en   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                rd_en   = 1'b1;
                state_d = S_ACC;
            end
            S_ACC: begin
                state_d = last_pair ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q <= '0;
                        idx_q <= '0;
                        rv_q  <= 1'b0;
                    end
                end
                S_ACC: begin
                    acc_q <= acc_next;
                    if (last_pair) begin
                        // Loaded on the edge into DONE so result and
                        // result_valid are already valid alongside done.
                        result_q <= act_next;
                        rv_q     <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign idx          = idx_q;
    assign result       = result_q;
    assign result_valid = rv_q;

endmodule
